binding_lane_serializer: RTL and testbench

Downstream consumer of the nine-lane binding-test datapath. Captures all `NLANES` parallel output lanes as one atomic snapshot through a valid/ready handshake, then streams them one lane per beat on a narrow output channel. A trailing checksum beat carries the modular sum of the lanes, so a single narrow port can carry the full frame off-block for checking.

---
 rtl/binding_lane_serializer.sv | 148 ++++++++++++++
 tb/tb_binding_lane_serializer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/binding_lane_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : binding_lane_serializer
//  Brief    : Captures NLANES parallel lanes as one snapshot and streams them
//             one lane per beat, followed by a modular-sum checksum beat.
//  Revision : 1.0 - initial release
// ============================================================================
module binding_lane_serializer #(
    parameter int NLANES      = 9,
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   io_in_valid,
    output logic                   io_in_ready,
    input  logic [WIDTH-1:0]       io_lane0,
    input  logic [WIDTH-1:0]       io_lane1,
    input  logic [WIDTH-1:0]       io_lane2,
    input  logic [WIDTH-1:0]       io_lane3,
    input  logic [WIDTH-1:0]       io_lane4,
    input  logic [WIDTH-1:0]       io_lane5,
    input  logic [WIDTH-1:0]       io_lane6,
    input  logic [WIDTH-1:0]       io_lane7,
    input  logic [WIDTH-1:0]       io_lane8,
    output logic                   io_out_valid,
    input  logic                   io_out_ready,
    output logic [WIDTH-1:0]       io_out_bits,
    output logic                   io_out_last,
    output logic [COUNT_WIDTH-1:0] io_frame_count
);

    localparam int                 c_IDX_W    = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NLANES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_SUM  = 2'd2;

    logic [WIDTH-1:0]       w_lanes [9];
    logic [WIDTH-1:0]       r_snapshot [NLANES];
    logic [WIDTH-1:0]       r_checksum;
    logic [WIDTH-1:0]       w_sum;
    logic [c_IDX_W-1:0]     r_idx;
    logic [c_IDX_W-1:0]     w_idx_inc;
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic                   w_cap;
    logic                   w_acc;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic [WIDTH-1:0]       r_out_bits;
    logic [COUNT_WIDTH-1:0] r_frame_count;
    logic                   w_valid_nxt;
    logic                   w_last_nxt;
    logic [WIDTH-1:0]       w_bits_nxt;

    assign w_lanes[0] = io_lane0;
    assign w_lanes[1] = io_lane1;
    assign w_lanes[2] = io_lane2;
    assign w_lanes[3] = io_lane3;
    assign w_lanes[4] = io_lane4;
    assign w_lanes[5] = io_lane5;
    assign w_lanes[6] = io_lane6;
    assign w_lanes[7] = io_lane7;
    assign w_lanes[8] = io_lane8;

    assign w_cap     = (r_state == c_IDLE) && io_in_valid;
    assign w_acc     = r_out_valid && io_out_ready;
    assign w_idx_inc = r_idx + c_IDX_W'(1);

    // Carry out of the top bit is intentionally discarded.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NLANES; i++) begin
            w_sum = w_sum + w_lanes[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (io_in_valid) w_state_nxt = c_SEND;
            c_SEND:  if (w_acc && (r_idx == c_LAST_IDX)) w_state_nxt = c_SUM;
            c_SUM:   if (w_acc) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Outputs are registered, so this computes the value each will take next.
    always_comb begin
        w_valid_nxt = (w_state_nxt != c_IDLE);
        w_last_nxt  = (w_state_nxt == c_SUM);
        w_bits_nxt  = r_out_bits;
        case (r_state)
            c_IDLE:  w_bits_nxt = w_cap ? w_lanes[0] : '0;
            c_SEND:  if (w_acc) w_bits_nxt = (r_idx == c_LAST_IDX) ? r_checksum : r_snapshot[w_idx_inc];
            c_SUM:   if (w_acc) w_bits_nxt = '0;
            default: w_bits_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NLANES; i++) begin
                r_snapshot[i] <= '0;
            end
            r_checksum    <= '0;
            r_idx         <= '0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_out_bits    <= '0;
            r_frame_count <= '0;
        end else begin
            r_out_valid <= w_valid_nxt;
            r_out_last  <= w_last_nxt;
            r_out_bits  <= w_bits_nxt;
            if (w_cap) begin
                for (int i = 0; i < NLANES; i++) begin
                    r_snapshot[i] <= w_lanes[i];
                end
                r_checksum <= w_sum;
                r_idx      <= '0;
            end else if ((r_state == c_SEND) && w_acc) begin
                r_idx <= (r_idx == c_LAST_IDX) ? '0 : w_idx_inc;
            end
            if ((r_state == c_SUM) && w_acc) begin
                r_frame_count <= r_frame_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign io_in_ready    = (r_state == c_IDLE);
    assign io_out_valid   = r_out_valid;
    assign io_out_last    = r_out_last;
    assign io_out_bits    = r_out_bits;
    assign io_frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_binding_lane_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_binding_lane_serializer
//  Brief    : Directed scoreboard bench for binding_lane_serializer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_binding_lane_serializer;

    localparam int NL = 9;
    localparam int W  = 8;

    typedef logic [NL-1:0][W-1:0] frame_t;

    logic   clk       = 1'b0;
    logic   reset     = 1'b0;
    logic   in_valid  = 1'b0;
    logic   out_ready = 1'b0;
    frame_t lanes     = '0;

    logic         in_ready_a, out_valid_a, last_a;
    logic [W-1:0] bits_a;
    logic [15:0]  count_a;
    logic         in_ready_b, out_valid_b, last_b;
    logic [W-1:0] bits_b;
    logic [1:0]   count_b;

    logic [W:0] q[$];
    logic [W:0] mon_e;
    int n_cmp = 0;
    int n_err = 0;
    int exp_frames = 0;

    always #5 clk = ~clk;

    binding_lane_serializer #(.NLANES(NL), .WIDTH(W), .COUNT_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .io_in_valid(in_valid), .io_in_ready(in_ready_a),
        .io_lane0(lanes[0]), .io_lane1(lanes[1]), .io_lane2(lanes[2]),
        .io_lane3(lanes[3]), .io_lane4(lanes[4]), .io_lane5(lanes[5]),
        .io_lane6(lanes[6]), .io_lane7(lanes[7]), .io_lane8(lanes[8]),
        .io_out_valid(out_valid_a), .io_out_ready(out_ready), .io_out_bits(bits_a),
        .io_out_last(last_a), .io_frame_count(count_a)
    );

    binding_lane_serializer #(.NLANES(NL), .WIDTH(W), .COUNT_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset), .io_in_valid(in_valid), .io_in_ready(in_ready_b),
        .io_lane0(lanes[0]), .io_lane1(lanes[1]), .io_lane2(lanes[2]),
        .io_lane3(lanes[3]), .io_lane4(lanes[4]), .io_lane5(lanes[5]),
        .io_lane6(lanes[6]), .io_lane7(lanes[7]), .io_lane8(lanes[8]),
        .io_out_valid(out_valid_b), .io_out_ready(out_ready), .io_out_bits(bits_b),
        .io_out_last(last_b), .io_frame_count(count_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] csum(input frame_t f);
        logic [W-1:0] s = '0;
        for (int k = 0; k < NL; k++) s = s + f[k];
        return s;
    endfunction

    // Scoreboard: each accepted beat must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset && out_valid_a && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_beat", 32'(out_valid_a), 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("beat_a", 32'({last_a, bits_a}), 32'(mon_e));
                check("beat_b", 32'({last_b, bits_b}), 32'(mon_e));
            end
        end
    end

    task automatic start_frame(input frame_t f);
        bit ok;
        bit done = 1'b0;
        lanes    = f;
        in_valid = 1'b1;
        for (int k = 0; k < NL; k++) q.push_back({1'b0, f[k]});
        q.push_back({1'b1, csum(f)});
        for (int c = 0; c < 200 && !done; c++) begin
            ok = in_ready_a;
            @(posedge clk); #1;
            if (ok) done = 1'b1;
        end
        if (!done) check("capture_timeout", 32'(in_ready_a), 32'd1);
        check("latency_valid", 32'(out_valid_a), 32'd1);
        check("latency_bits", 32'(bits_a), 32'(f[0]));
        check("busy_in_ready", 32'(in_ready_a), 32'd0);
    endtask

    task automatic wait_qsize(input int n, output int cycles);
        cycles = 0;
        while (q.size() != n && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (q.size() != n) check("drain_timeout", 32'(q.size()), 32'(n));
    endtask

    task automatic finish_frame(output int cycles);
        wait_qsize(0, cycles);
        exp_frames++;
        check("idle_in_ready", 32'(in_ready_a), 32'd1);
        check("frame_count_a", 32'(count_a), 32'(exp_frames[15:0]));
        check("frame_count_b", 32'(count_b), 32'(exp_frames[1:0]));
    endtask

    initial begin
        frame_t f;
        frame_t aa;
        int     cyc;

        // Reset held low with a valid snapshot offered: nothing may be captured.
        in_valid = 1'b1;
        lanes    = '1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready_a), 32'd1);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_out_bits", 32'(bits_a), 32'd0);
        check("rst_out_last", 32'(last_a), 32'd0);
        check("rst_count_a", 32'(count_a), 32'd0);
        check("rst_count_b", 32'(count_b), 32'd0);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", 32'(out_valid_a), 32'd0);

        // Ready with nothing to send must not move anything.
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ready_valid", 32'(out_valid_a), 32'd0);
        check("idle_ready_count", 32'(count_a), 32'd0);

        // Basic frame 1..9, back-to-back beats.
        for (int k = 0; k < NL; k++) f[k] = W'(k + 1);
        start_frame(f);
        in_valid = 1'b0;
        finish_frame(cyc);
        check("basic_beat_cycles", 32'(cyc), 32'd10);

        // Checksum overflow.
        for (int k = 0; k < NL; k++) f[k] = 8'hFF;
        start_frame(f);
        in_valid = 1'b0;
        finish_frame(cyc);

        // Backpressure at beat 3.
        for (int k = 0; k < NL; k++) f[k] = W'(8'h30 + k);
        start_frame(f);
        in_valid = 1'b0;
        wait_qsize(7, cyc);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_bits", 32'(bits_a), 32'(f[3]));
            check("bp_valid", 32'(out_valid_a), 32'd1);
            check("bp_last", 32'(last_a), 32'd0);
            check("bp_in_ready", 32'(in_ready_a), 32'd0);
        end
        out_ready = 1'b1;
        finish_frame(cyc);

        // Snapshot isolation: lanes change and valid stays high mid-frame.
        for (int k = 0; k < NL; k++) f[k] = W'(8'h50 + 3 * k);
        for (int k = 0; k < NL; k++) aa[k] = 8'hAA;
        start_frame(f);
        start_frame(aa);
        check("iso_pending", 32'(q.size()), 32'd10);
        exp_frames++;
        check("iso_count_a", 32'(count_a), 32'(exp_frames[15:0]));
        check("iso_count_b", 32'(count_b), 32'(exp_frames[1:0]));
        in_valid = 1'b0;
        finish_frame(cyc);

        // Asynchronous reset at beat 4.
        for (int k = 0; k < NL; k++) f[k] = W'(8'h70 + k);
        start_frame(f);
        in_valid = 1'b0;
        wait_qsize(6, cyc);
        check("pre_rst_bits", 32'(bits_a), 32'(f[4]));
        #2;
        reset = 1'b0;
        #1;
        check("async_valid", 32'(out_valid_a), 32'd0);
        check("async_count_a", 32'(count_a), 32'd0);
        check("async_count_b", 32'(count_b), 32'd0);
        check("async_in_ready", 32'(in_ready_a), 32'd1);
        q.delete();
        exp_frames = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Clean frame after reset.
        for (int k = 0; k < NL; k++) f[k] = W'(8'h10 + k);
        start_frame(f);
        in_valid = 1'b0;
        finish_frame(cyc);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
